// File: rtl/ram_dp_clr.sv
// Dual-address RAM (one write port, one read port) with a post-reset clear sequencer.
// Optional macro RAM_OUTREG_EN adds a second output register stage (read latency 2).
module ram_dp_clr #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 65536,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rden,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [0:0]      ST_CLEAR = 1'b0;
  localparam logic [0:0]      ST_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              wr_in_range_s, rd_in_range_s, rd_fire_s, byp_hit_s;
  logic [IDX_W-1:0]  rd_idx_s;

  logic [DATA_W-1:0] ram_rd_q;
  logic [DATA_W-1:0] byp_data_q;
  logic              byp_q, zero_q, rd_valid_q;
  logic [DATA_W-1:0] rd_q_s;

  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_A);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_A);
  assign rd_idx_s      = rd_addr[IDX_W-1:0];
  assign rd_fire_s     = (state_q == ST_RUN) && rden;
  assign byp_hit_s     = rd_in_range_s && wren && (wr_addr == rd_addr);

  // Clear sequencer next state and counter
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_d   = ST_RUN;
        clr_cnt_d = clr_cnt_q;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Single write port shared between the clear sequencer and user writes
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (state_q == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_q;
      mem_wdata_s = CLEAR_VAL;
    end else begin
      mem_we_s    = wren && wr_in_range_s;
      mem_waddr_s = wr_addr[IDX_W-1:0];
      mem_wdata_s = wr_data;
    end
  end

  // Memory array write (no reset so it maps onto block RAM)
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Synchronous array read; out-of-range reads never touch the array
  always_ff @(posedge clock) begin
    if (rd_fire_s && rd_in_range_s) begin
      ram_rd_q <= mem[rd_idx_s];
    end
  end

  // Registered select flags: write-first bypass and out-of-range zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      zero_q     <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire_s;
      if (rd_fire_s) begin
        zero_q     <= !rd_in_range_s;
        byp_q      <= byp_hit_s;
        byp_data_q <= wr_data;
      end
    end
  end

  // Read result mux; zero_q is set by reset so q starts at 0
  always_comb begin
    rd_q_s = ram_rd_q;
    if (zero_q) begin
      rd_q_s = '0;
    end else if (byp_q) begin
      rd_q_s = byp_data_q;
    end else begin
      rd_q_s = ram_rd_q;
    end
  end

`ifdef RAM_OUTREG_EN
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  // Output pipeline stage; data only advances with a valid read so q holds
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        out_data_q <= rd_q_s;
      end
    end
  end

  assign q       = out_data_q;
  assign q_valid = out_valid_q;
`else
  assign q       = rd_q_s;
  assign q_valid = rd_valid_q;
`endif

  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr (DEPTH=12, CLEAR_VAL=A5A5); works with or without RAM_OUTREG_EN.
module tb_ram_dp_clr;

`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wren, rden;
  logic [15:0] q;
  logic        q_valid, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ram_dp_clr #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .DEPTH    (12),
    .CLEAR_VAL(16'hA5A5)
  ) dut (
    .clock  (clk),
    .reset  (rst_n),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wren   (wren),
    .rd_addr(rd_addr),
    .rden   (rden),
    .q      (q),
    .q_valid(q_valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents q_valid
  always @(negedge clk) begin
    if (q_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_q_valid", {31'b0, q_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_data"}, {16'b0, q}, {16'b0, mon_e.data});
        chk({mon_e.name, "_latency"}, cyc, mon_e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      chk({mon_e.name, "_missing_valid"}, {31'b0, q_valid}, 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren = 1'b0;
    rden = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] d, input string n);
    rden    = 1'b1;
    rd_addr = a;
    sb.push_back('{d, cyc + LAT, n});
  endtask

  task automatic count_clear(input string n);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk(n, k, 32'd12);
  endtask

  function automatic logic [15:0] exp_scan(input int i);
    case (i)
      1:       return 16'h0003;
      2:       return 16'h5555;
      5:       return 16'h1234;
      default: return 16'hA5A5;
    endcase
  endfunction

  initial begin
    rst_n   = 1'b1;
    wr_addr = 4'd0;
    rd_addr = 4'd0;
    wr_data = 16'h0000;
    wren    = 1'b0;
    rden    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_q", {16'b0, q}, 32'd0);
    chk("reset_q_valid", {31'b0, q_valid}, 32'd0);

    // Scenario 1: clear length with requests that must be ignored, then read back
    wren = 1'b1; wr_addr = 4'd0; wr_data = 16'hDEAD;
    rden = 1'b1; rd_addr = 4'd2;
    rst_n = 1'b1;
    count_clear("clear_len");
    idle();
    for (int i = 0; i < 12; i++) begin
      rd(4'(i), 16'hA5A5, "s1_clear_read");
      step();
    end
    idle();
    repeat (LAT + 1) step();

    // Scenario 2: write then read, then q holds with q_valid low
    wren = 1'b1; wr_addr = 4'd1; wr_data = 16'h0003;
    step();
    wren = 1'b0;
    rd(4'd1, 16'h0003, "s2_read");
    step();
    rden = 1'b0;
    repeat (LAT) step();
    chk("s2_q_valid_low", {31'b0, q_valid}, 32'd0);
    chk("s2_q_hold", {16'b0, q}, 32'h0003);

    // Scenario 3: read-during-write same address, then different addresses
    wren = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    rd(4'd5, 16'h1234, "s3_write_first");
    step();
    wren = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
    rd(4'd3, 16'hA5A5, "s3_indep");
    step();
    idle();
    rd(4'd5, 16'h1234, "s3_reread");
    step();
    idle();
    repeat (LAT + 1) step();

    // Scenario 4: out-of-range write and reads, then contiguous scan
    wren = 1'b1; wr_addr = 4'd13; wr_data = 16'hFFFF;
    step();
    idle();
    rd(4'd13, 16'h0000, "s4_oob13");
    step();
    for (int i = 0; i < 12; i++) begin
      rd(4'(i), exp_scan(i), "s4_scan");
      step();
    end
    rd(4'd15, 16'h0000, "s4_oob15");
    step();
    idle();
    repeat (LAT + 1) step();

    // Scenario 5: reset during run and mid-clear
    wren = 1'b1; wr_addr = 4'd8; wr_data = 16'h0007;
    step();
    idle();
    rd(4'd8, 16'h0007, "s5_pre");
    step();
    idle();
    repeat (LAT + 1) step();
    rst_n = 1'b0;
    #1;
    chk("s5_reset_q", {16'b0, q}, 32'd0);
    chk("s5_reset_q_valid", {31'b0, q_valid}, 32'd0);
    chk("s5_reset_busy", {31'b0, busy}, 32'd1);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("s5_midclear_busy", {31'b0, busy}, 32'd1);
    step();
    rst_n = 1'b1;
    count_clear("s5_clear_len");
    rd(4'd8, 16'hA5A5, "s5_addr8");
    step();
    rd(4'd1, 16'hA5A5, "s5_addr1");
    step();
    idle();
    repeat (LAT + 2) step();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised synchronous RAM with one write port and one read port, each with its own address. It is the successor to the 16-bit single-port RAM used by the processor. It adds configurable width and depth, a separate read address, a read-valid flag, and defined read-during-write behaviour. After reset it runs a hardware clear sequencer, so data memory starts in a known state without a software init loop.

Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 16, address width in bits
- DEPTH, 65536, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W
- CLEAR_VAL, 0, value written to every word by the clear sequencer (DATA_W bits)

Ports:
- clock  in  1  single system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wren  in  1  write enable
- rd_addr  in  ADDR_W  read address
- rden  in  1  read enable
- q  out  DATA_W  read data
- q_valid  out  1  q holds the result of a read issued on the previous edge (two edges earlier with the optional feature)
- busy  out  1  clear sequencer active; wren and rden are ignored

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, clear counter=0
  - busy=1, q=0, q_valid=0
  - Memory array contents are not reset directly.
- CLEAR state:
  - Each edge writes CLEAR_VAL to mem[counter], then counter+1.
  - On the edge that writes index DEPTH-1: state goes to RUN and busy goes to 0.
  - busy is therefore high for exactly DEPTH rising edges after reset deasserts.
  - wren and rden are ignored; q holds and q_valid stays 0.
- RUN state, write:
  - On the edge with wren=1 and wr_addr<DEPTH: mem[wr_addr] <= wr_data.
  - If wr_addr>=DEPTH: write discarded, no other effect.
- RUN state, read (latency 1):
  - On the edge with rden=1: q <= mem[rd_addr] and q_valid <= 1.
  - If rd_addr>=DEPTH: q <= 0, q_valid <= 1.
  - On an edge with rden=0: q_valid <= 0 and q holds its last value.
- Read-during-write, same cycle:
  - If wren=1, rden=1 and rd_addr==wr_addr (<DEPTH): write-first, q <= wr_data.
  - Different addresses: fully independent.
- Back-to-back reads: rden may be held high. Each edge produces a new q with q_valid=1 continuously.
- Reset mid-operation (including mid-CLEAR): immediately returns to the reset values above. Clear restarts from index 0; any in-flight read is dropped (q_valid=0).
- Address width: only the full ADDR_W value is compared against DEPTH; there is no wrap-around or aliasing.
- Implementation: the array must infer block RAM.
  - Clear writes share the write port through a mux.
  - The write-first bypass is a registered compare, not an asynchronous read.

Optional Feature:
Macro: RAM_OUTREG_EN
- Defined:
  - An extra output register is added after the memory read stage; read latency becomes 2 edges.
  - q_valid is pipelined alongside q, so it asserts 2 edges after rden.
  - The write-first bypass value travels through the same pipeline.
  - Reset clears both stages to 0.
  - During CLEAR, a pipeline stage holding valid=1 drains normally; no new entries are accepted.
- Not defined: latency is 1 as described in Behaviour; no extra register.

Test Plan:
All scenarios use DATA_W=16, ADDR_W=4, DEPTH=12, CLEAR_VAL=16'hA5A5.
1. Release reset → busy=1 for exactly 12 edges then 0; reading addresses 0..11 returns 16'hA5A5 with q_valid=1 one edge after each rden.
2. Write 16'h0003 to address 1; next cycle rden at address 1 → q=16'h0003 and q_valid=1 one edge later. The following cycle with rden=0 → q_valid=0 and q still 16'h0003.
3. Same cycle: wren=1, rden=1, both addresses 5, wr_data=16'h1234 → q=16'h1234 next edge; a later read of address 5 also returns 16'h1234.
4. Write 16'hFFFF to address 13, then read address 13 → q=16'h0000 with q_valid=1. Addresses 0..11 are unchanged (data from scenario 1 still intact, apart from addresses 1 and 5 written in scenarios 2 and 3).
5. Assert reset at the 6th CLEAR edge, with address 8 previously holding 16'h0007 → q=0, q_valid=0 at once. After release, busy is high for a full 12 edges again and address 8 reads 16'hA5A5.
6. With RAM_OUTREG_EN defined, repeat scenario 2 → q=16'h0003 and q_valid=1 exactly 2 edges after rden. rden held high over addresses 0,1,2 → a continuous q_valid=1 stream in order.
